// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue fetch pair queue.
// Holds the stored pair layout, the NOP filler and the pointer-width helper.
package fetch_pkg;

  localparam int FETCH_WIDTH = 32;
  localparam logic [FETCH_WIDTH-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [FETCH_WIDTH-1:0] instr1;
    logic [FETCH_WIDTH-1:0] instr2;
    logic [FETCH_WIDTH-1:0] pc1;
    logic [FETCH_WIDTH-1:0] pc2;
  } fetch_pair_t;

  // Index bits plus one wrap bit so full and empty can be told apart.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_ptr.sv
// Wrap-bit queue pointer: increments on inc, synchronous clear wins over inc.
// Async active-low reset to zero; no backpressure of its own.
module fetch_queue_ptr #(
  parameter int PW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PW'(1);
    end
  end

endmodule

// File: rtl/fetch_pair_queue.sv
// Circular queue of fetched instruction pairs feeding dual decode; push-to-visible 1 cycle.
// FullF stalls the PC unit and pushes while full are dropped; FlushD empties the queue.
module fetch_pair_queue
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     PushF,
  input  logic [WIDTH-1:0]         PCF1,
  input  logic [WIDTH-1:0]         PCF2,
  input  logic [WIDTH-1:0]         InstrF1,
  input  logic [WIDTH-1:0]         InstrF2,
  output logic                     FullF,
  input  logic                     FlushD,
  input  logic                     PopD,
  output logic                     ValidD,
  output logic [WIDTH-1:0]         InstrD1,
  output logic [WIDTH-1:0]         InstrD2,
  output logic [WIDTH-1:0]         PCD1,
  output logic [WIDTH-1:0]         PCD2,
  output logic [WIDTH-1:0]         PCPlus4D1,
  output logic [WIDTH-1:0]         PCPlus4D2,
  output logic [$clog2(DEPTH):0]   CountQ
);

  localparam int PW = ptr_w(DEPTH);
  localparam int IW = PW - 1;

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          empty;
  logic          push_acc;
  logic          pop_acc;
  fetch_pair_t   mem [DEPTH];
  fetch_pair_t   head;

  // Status comes from registered pointers only, never from this cycle's requests.
  assign empty  = (rd_ptr == wr_ptr);
  assign FullF  = (rd_ptr[IW-1:0] == wr_ptr[IW-1:0]) && (rd_ptr[IW] != wr_ptr[IW]);
  assign ValidD = !empty;
  assign CountQ = wr_ptr - rd_ptr;

  assign push_acc = PushF && !FullF && !FlushD;
  assign pop_acc  = PopD && ValidD && !FlushD;

  fetch_queue_ptr #(.PW(PW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (push_acc),
    .clr   (FlushD),
    .ptr   (wr_ptr)
  );

  fetch_queue_ptr #(.PW(PW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pop_acc),
    .clr   (FlushD),
    .ptr   (rd_ptr)
  );

  // Storage needs no reset: entries are only visible once a pointer covers them.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr[IW-1:0]] <= '{
        instr1: FETCH_WIDTH'(InstrF1),
        instr2: FETCH_WIDTH'(InstrF2),
        pc1:    FETCH_WIDTH'(PCF1),
        pc2:    FETCH_WIDTH'(PCF2)
      };
    end
  end

  assign head = mem[rd_ptr[IW-1:0]];

  always_comb begin
    InstrD1   = WIDTH'(NOP_INSTR);
    InstrD2   = WIDTH'(NOP_INSTR);
    PCD1      = '0;
    PCD2      = '0;
    PCPlus4D1 = '0;
    PCPlus4D2 = '0;
    if (ValidD) begin
      InstrD1   = WIDTH'(head.instr1);
      InstrD2   = WIDTH'(head.instr2);
      PCD1      = WIDTH'(head.pc1);
      PCD2      = WIDTH'(head.pc2);
      PCPlus4D1 = WIDTH'(head.pc1) + WIDTH'(4);
      PCPlus4D2 = WIDTH'(head.pc2) + WIDTH'(4);
    end
  end

endmodule

// File: tb/tb_fetch_pair_queue.sv
// Directed vector bench for fetch_pair_queue: table rows plus hand sequences
// for async reset, flush while full and status independence from requests.
module tb_fetch_pair_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             PushF = 1'b0;
  logic [WIDTH-1:0] PCF1 = '0;
  logic [WIDTH-1:0] PCF2 = '0;
  logic [WIDTH-1:0] InstrF1 = '0;
  logic [WIDTH-1:0] InstrF2 = '0;
  logic             FullF;
  logic             FlushD = 1'b0;
  logic             PopD = 1'b0;
  logic             ValidD;
  logic [WIDTH-1:0] InstrD1, InstrD2, PCD1, PCD2, PCPlus4D1, PCPlus4D2;
  logic [$clog2(DEPTH):0] CountQ;

  fetch_pair_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .PushF     (PushF),
    .PCF1      (PCF1),
    .PCF2      (PCF2),
    .InstrF1   (InstrF1),
    .InstrF2   (InstrF2),
    .FullF     (FullF),
    .FlushD    (FlushD),
    .PopD      (PopD),
    .ValidD    (ValidD),
    .InstrD1   (InstrD1),
    .InstrD2   (InstrD2),
    .PCD1      (PCD1),
    .PCD2      (PCD2),
    .PCPlus4D1 (PCPlus4D1),
    .PCPlus4D2 (PCPlus4D2),
    .CountQ    (CountQ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        push;
    logic        pop;
    logic        flush;
    logic [31:0] pc1;
    logic [31:0] pc2;
    logic        ev;
    logic        ef;
    int          ec;
    logic [31:0] ep1;
    logic [31:0] ep2;
  } vec_t;

  vec_t vt[$];
  int checks = 0;
  int errors = 0;

  // Instruction words are tagged by slot so a swap shows up in the data too.
  function automatic logic [31:0] i1_of(input logic [31:0] pc);
    return 32'hA000_0000 ^ pc;
  endfunction
  function automatic logic [31:0] i2_of(input logic [31:0] pc);
    return 32'hB000_0000 ^ pc;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic ev, input logic ef, input int ec,
                          input logic [31:0] p1, input logic [31:0] p2);
    chk({tag, " ValidD"}, 32'(ValidD), 32'(ev));
    chk({tag, " FullF"}, 32'(FullF), 32'(ef));
    chk({tag, " CountQ"}, 32'(CountQ), 32'(ec));
    chk({tag, " PCD1"}, PCD1, ev ? p1 : 32'h0);
    chk({tag, " PCD2"}, PCD2, ev ? p2 : 32'h0);
    chk({tag, " PCPlus4D1"}, PCPlus4D1, ev ? p1 + 32'd4 : 32'h0);
    chk({tag, " PCPlus4D2"}, PCPlus4D2, ev ? p2 + 32'd4 : 32'h0);
    chk({tag, " InstrD1"}, InstrD1, ev ? i1_of(p1) : NOP);
    chk({tag, " InstrD2"}, InstrD2, ev ? i2_of(p2) : NOP);
  endtask

  task automatic addv(input logic push, input logic pop, input logic flush,
                      input logic [31:0] pc1, input logic [31:0] pc2,
                      input logic ev, input logic ef, input int ec,
                      input logic [31:0] ep1, input logic [31:0] ep2);
    vec_t v;
    v.push = push; v.pop = pop; v.flush = flush; v.pc1 = pc1; v.pc2 = pc2;
    v.ev = ev; v.ef = ef; v.ec = ec; v.ep1 = ep1; v.ep2 = ep2;
    vt.push_back(v);
  endtask

  task automatic drive(input logic push, input logic pop, input logic flush,
                       input logic [31:0] pc1, input logic [31:0] pc2);
    PushF = push; PopD = pop; FlushD = flush;
    PCF1 = pc1; PCF2 = pc2; InstrF1 = i1_of(pc1); InstrF2 = i2_of(pc2);
  endtask

  initial begin
    // Fill then overfill; a push offered while full is refused even with PopD.
    addv(1, 0, 0, 32'h00, 32'h04, 1, 0, 1, 32'h00, 32'h04);
    addv(1, 0, 0, 32'h08, 32'h0C, 1, 0, 2, 32'h00, 32'h04);
    addv(1, 0, 0, 32'h10, 32'h14, 1, 0, 3, 32'h00, 32'h04);
    addv(1, 0, 0, 32'h18, 32'h1C, 1, 1, 4, 32'h00, 32'h04);
    addv(1, 0, 0, 32'h20, 32'h24, 1, 1, 4, 32'h00, 32'h04);
    addv(1, 1, 0, 32'h20, 32'h24, 1, 0, 3, 32'h08, 32'h0C);
    addv(0, 1, 0, 32'h0,  32'h0,  1, 0, 2, 32'h10, 32'h14);
    addv(0, 1, 0, 32'h0,  32'h0,  1, 0, 1, 32'h18, 32'h1C);
    addv(0, 1, 0, 32'h0,  32'h0,  0, 0, 0, 32'h0,  32'h0);
    addv(0, 1, 0, 32'h0,  32'h0,  0, 0, 0, 32'h0,  32'h0);
    // Steady push+pop: occupancy holds at 1 while both pointers wrap.
    addv(1, 0, 0, 32'h30, 32'h34, 1, 0, 1, 32'h30, 32'h34);
    for (int k = 0; k < 10; k++) begin
      logic [31:0] p;
      p = 32'h38 + 32'(k) * 32'h8;
      addv(1, 1, 0, p, p + 32'h4, 1, 0, 1, p, p + 32'h4);
    end
    addv(0, 1, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    // Flush with push and pop in the same cycle, then a fresh push.
    addv(1, 0, 0, 32'h200, 32'h204, 1, 0, 1, 32'h200, 32'h204);
    addv(1, 0, 0, 32'h208, 32'h20C, 1, 0, 2, 32'h200, 32'h204);
    addv(1, 0, 0, 32'h210, 32'h214, 1, 0, 3, 32'h200, 32'h204);
    addv(1, 1, 1, 32'h218, 32'h21C, 0, 0, 0, 32'h0,   32'h0);
    addv(1, 0, 0, 32'h40,  32'h44,  1, 0, 1, 32'h40,  32'h44);
    // Pair fetched after a branch in pipeline 2: slot order kept as given.
    addv(1, 0, 0, 32'h104, 32'h100, 1, 0, 2, 32'h40,  32'h44);
    addv(0, 1, 0, 32'h0,   32'h0,   1, 0, 1, 32'h104, 32'h100);

    repeat (2) @(posedge clk);
    #1;
    chk_head("reset", 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].push, vt[i].pop, vt[i].flush, vt[i].pc1, vt[i].pc2);
      @(posedge clk);
      #1;
      chk_head($sformatf("row%0d", i), vt[i].ev, vt[i].ef, vt[i].ec, vt[i].ep1, vt[i].ep2);
    end

    // Second entry, then async reset mid-cycle.
    drive(1, 0, 0, 32'h300, 32'h304);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 32'h0, 32'h0);
    chk("pre_rst CountQ", 32'(CountQ), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_head("async_rst", 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 32'h400, 32'h404);
    @(posedge clk);
    #1;
    chk_head("post_rst push", 1, 0, 1, 32'h400, 32'h404);

    // Fill to full, then raise pop+flush mid-cycle: status must not move until the edge.
    for (int k = 1; k < DEPTH; k++) begin
      drive(1, 0, 0, 32'h500 + 32'(k) * 32'h8, 32'h504 + 32'(k) * 32'h8);
      @(posedge clk);
      #1;
    end
    drive(0, 0, 0, 32'h0, 32'h0);
    chk_head("full", 1, 1, 4, 32'h400, 32'h404);
    drive(1, 1, 1, 32'h600, 32'h604);
    #1;
    chk("comb FullF", 32'(FullF), 32'd1);
    chk("comb CountQ", 32'(CountQ), 32'd4);
    chk("comb ValidD", 32'(ValidD), 32'd1);
    @(posedge clk);
    #1;
    chk_head("flush_full", 0, 0, 0, 32'h0, 32'h0);
    drive(1, 0, 0, 32'h40, 32'h44);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 32'h0, 32'h0);
    chk_head("post_flush push", 1, 0, 1, 32'h40, 32'h44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
